// File: rtl/mem_req_ctrl.sv
// Request-side controller for a single-port synchronous memory: optional
// post-reset zero sweep, credit-limited request issue and an in-order read response FIFO.
module mem_req_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RSP_DEPTH  = 2,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o,
  output logic              mem_srst_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              srst_q;
  logic              pend_q;
  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q;
  logic [CW:0]       credit;
  logic              fire, push, pop;

  // Credit counts the read in flight inside the memory as well as queued data,
  // so the FIFO can never be overrun; a same-cycle pop is deliberately ignored.
  assign credit      = {1'b0, cnt_q} + (CW+1)'(pend_q);
  assign fire        = req_valid_i & req_ready_o;
  assign push        = pend_q;
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_valid_o = (cnt_q != '0);
  assign rsp_rdata_o = fifo_q[rptr_q];
  assign mem_srst_o  = srst_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_RESET: state_d = (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
      S_CLEAR: begin
        mem_we_o   = 1'b1;
        mem_addr_o = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        busy_o      = 1'b0;
        req_ready_o = (credit < (CW+1)'(RSP_DEPTH));
        mem_addr_o  = req_addr_i;
        mem_wdata_o = req_wdata_i;
        mem_we_o    = req_valid_i & req_ready_o & req_we_i;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= S_RESET;
      clr_cnt_q <= '0;
      srst_q    <= 1'b1;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      srst_q    <= 1'b0;
      pend_q    <= fire & ~req_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= mem_rdata_i;
        wptr_q <= (wptr_q == PW'(RSP_DEPTH-1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) rptr_q <= (rptr_q == PW'(RSP_DEPTH-1)) ? '0 : rptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!arst_ni)
    !(push && !pop && (cnt_q == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: memory model, shadow-array scoreboard with
// outstanding-read queue, directed and random traffic, mid-stream reset.
module tb_mem_req_ctrl;
  localparam int AW = 4, DW = 32, D = 2, WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, busy, msrst, mwe;
  logic [DW-1:0] rsp_rdata, mwdata, mrdata;
  logic [AW-1:0] maddr;
  logic          ready1, rsp_valid1, busy1, msrst1, mwe1;
  logic [DW-1:0] rsp_rdata1, mwdata1;
  logic [AW-1:0] maddr1;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(D), .INIT_CLEAR(1)) dut (
    .clk_i(clk), .arst_ni(arst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .busy_o(busy), .mem_srst_o(msrst), .mem_addr_o(maddr), .mem_we_o(mwe),
    .mem_wdata_o(mwdata), .mem_rdata_i(mrdata));

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(D), .INIT_CLEAR(0)) dut_nc (
    .clk_i(clk), .arst_ni(arst_n), .req_valid_i(1'b0), .req_ready_o(ready1),
    .req_we_i(1'b0), .req_addr_i('0), .req_wdata_i('0),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(1'b0), .rsp_rdata_o(rsp_rdata1),
    .busy_o(busy1), .mem_srst_o(msrst1), .mem_addr_o(maddr1), .mem_we_o(mwe1),
    .mem_wdata_o(mwdata1), .mem_rdata_i('0));

  // Single-port memory with registered read; starts with junk so the sweep matters.
  logic [DW-1:0] mem [WORDS];
  initial for (int i = 0; i < WORDS; i++) mem[i] = $urandom | 32'h1;
  always @(posedge clk) begin
    if (mwe) mem[maddr] <= mwdata;
    mrdata <= msrst ? '0 : mem[maddr];
  end

  typedef struct { logic [DW-1:0] d; int t; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] shadow [WORDS];
  int            cyc, checks, errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One RUN cycle: drive, check at negedge against the model, commit at posedge.
  task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input bit rr, output bit fired);
    bit exp_rdy, exp_v, popped;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; rsp_ready = rr;
    @(negedge clk);
    exp_rdy = (q.size() < D);
    exp_v   = (q.size() > 0) && (cyc >= q[0].t + 2);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) chk("rsp_rdata", rsp_rdata, q[0].d);
    chk("mem_we", 32'(mwe), 32'(v & exp_rdy & we));
    if (v) chk("mem_addr", 32'(maddr), 32'(a));
    if (v && we) chk("mem_wdata", mwdata, wd);
    chk("busy_run", 32'(busy), 32'(0));
    fired  = v & req_ready;
    popped = rsp_valid & rr;
    @(posedge clk);
    if (popped && q.size() > 0) void'(q.pop_front());
    if (fired) begin
      if (we) shadow[a] = wd;
      else    q.push_back('{shadow[a], cyc});
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    bit f;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, rr, f);
  endtask

  task automatic do_reset();
    arst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_rdata", rsp_rdata, 32'(0));
    chk("rst_busy", 32'(busy), 32'(1));
    chk("rst_srst", 32'(msrst), 32'(1));
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_we", 32'(mwe), 32'(0));
    chk("rst_addr", 32'(maddr), 32'(0));
    chk("rst_wdata", mwdata, 32'(0));
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("rel_busy", 32'(busy), 32'(1));
    chk("rel_srst", 32'(msrst), 32'(1));
    chk("rel_we", 32'(mwe), 32'(0));
    chk("nc_rel_ready", 32'(ready1), 32'(0));
    chk("nc_rel_busy", 32'(busy1), 32'(1));
    for (int k = 1; k <= WORDS; k++) begin
      @(negedge clk);
      chk("clr_busy", 32'(busy), 32'(1));
      chk("clr_srst", 32'(msrst), 32'(0));
      chk("clr_we", 32'(mwe), 32'(1));
      chk("clr_addr", 32'(maddr), 32'(k-1));
      chk("clr_wdata", mwdata, 32'(0));
      chk("clr_ready", 32'(req_ready), 32'(0));
      chk("nc_ready", 32'(ready1), 32'(1));
      chk("nc_busy", 32'(busy1), 32'(0));
    end
    @(posedge clk); #1;
    q.delete();
    cyc = 0;
    for (int i = 0; i < WORDS; i++) shadow[i] = '0;
  endtask

  initial begin
    bit f;
    int n;
    checks = 0; errs = 0;
    #1;
    do_reset();

    // Swept array reads back zero.
    step(1, 0, 4'd7, '0, 1, f);
    idle(3, 1);

    // Write then read in the next cycle.
    step(1, 1, 4'h2, 32'hDEADBEEF, 1, f);
    step(1, 0, 4'h2, '0, 1, f);
    idle(1, 1);
    chk("wr_rd_valid", 32'(rsp_valid), 32'(1));
    chk("wr_rd_data", rsp_rdata, 32'hDEADBEEF);
    idle(2, 1);

    // Credit limit with the response side stalled.
    step(1, 1, 4'd1, 32'h11, 1, f);
    step(1, 1, 4'd2, 32'h22, 1, f);
    step(1, 1, 4'd3, 32'h33, 1, f);
    step(1, 0, 4'd1, '0, 0, f);
    step(1, 0, 4'd2, '0, 0, f);
    for (int i = 0; i < 4; i++) step(1, 0, 4'd3, '0, 0, f);
    n = 0; f = 0;
    while (!f && n < 10) begin step(1, 0, 4'd3, '0, 1, f); n++; end
    chk("read3_accepted", 32'(f), 32'(1));
    idle(5, 1);

    // Random traffic with the response ready toggling every cycle.
    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, ($urandom % 3) == 0, AW'($urandom), $urandom, i[0], f);
    idle(6, 1);

    // Reset with two responses queued.
    step(1, 1, 4'd4, 32'hA5A5A5A5, 1, f);
    step(1, 0, 4'd4, '0, 0, f);
    step(1, 0, 4'd2, '0, 0, f);
    idle(3, 0);
    #2;
    do_reset();
    idle(5, 1);
    step(1, 0, 4'd4, '0, 1, f);
    step(1, 0, 4'd2, '0, 1, f);
    idle(4, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
